// File: rtl/nec_stack_sequencer.sv
// Stack sequencer: walks the push/pop masks of a decoded instruction and issues
// one word-sized SS-relative bus transfer per selected register, tracking SP.
module nec_stack_sequencer (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [15:0] push_mask_i,
  input  logic [15:0] pop_mask_i,
  input  logic [15:0] sp_in_i,
  output logic        busy_o,
  output logic [3:0]  reg_sel_o,
  input  logic [15:0] reg_wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [15:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic [3:0]  wb_sel_o,
  output logic [15:0] wb_data_o,
  output logic [15:0] sp_out_o,
  output logic        sp_we_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, PUSH, POP, FINISH} state_e;

  localparam logic [3:0]  BIT_SP   = 4'd4;
  localparam logic [3:0]  BIT_SKIP = 4'd5;
  localparam logic [15:0] SKIP_M   = 16'h0020;

  state_e      state_q, state_d;
  logic [15:0] push_q, push_d, pop_q, pop_d;
  logic [15:0] sp_q, sp_d, sp_start_q, sp_start_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [15:0] wb_data_q, wb_data_d;

  function automatic logic [3:0] lowest(input logic [15:0] m);
    lowest = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) lowest = 4'(i);
  endfunction

  function automatic logic [3:0] highest(input logic [15:0] m);
    highest = '0;
    for (int i = 0; i < 16; i++) if (m[i]) highest = 4'(i);
  endfunction

  logic        in_push, in_pop, xfer;
  logic [3:0]  push_idx, pop_idx;
  logic [15:0] push_rem, pop_rem;

  assign in_push  = (state_q == PUSH);
  assign in_pop   = (state_q == POP);
  assign push_idx = lowest(push_q);
  assign pop_idx  = highest(pop_q);
  assign push_rem = push_q & ~(16'b1 << push_idx);
  assign pop_rem  = pop_q & ~(16'b1 << pop_idx);
  assign xfer     = bus_req_o & bus_ack_i;

  // Request fields decode from state that only moves on ack, so they hold while waiting.
  assign bus_req_o   = in_push | in_pop;
  assign bus_we_o    = in_push;
  assign reg_sel_o   = in_push ? push_idx : (in_pop ? pop_idx : 4'd0);
  assign bus_addr_o  = in_push ? sp_q - 16'd2 : (in_pop ? sp_q : 16'd0);
  assign bus_wdata_o = !in_push ? 16'd0 : (push_idx == BIT_SP ? sp_start_q : reg_wdata_i);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FINISH);
  assign sp_we_o     = (state_q == FINISH);
  assign sp_out_o    = (state_q == FINISH) ? sp_q : 16'd0;
  assign wb_valid_o  = wb_valid_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_data_o   = wb_data_q;

  always_comb begin
    state_d    = state_q;
    push_d     = push_q;
    pop_d      = pop_q;
    sp_d       = sp_q;
    sp_start_d = sp_start_q;
    wb_valid_d = 1'b0;
    wb_sel_d   = wb_sel_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: if (start_i) begin
        push_d     = push_mask_i & ~SKIP_M;
        pop_d      = pop_mask_i;
        sp_d       = sp_in_i;
        sp_start_d = sp_in_i;
        if (|(push_mask_i & ~SKIP_M)) state_d = PUSH;
        else if (|pop_mask_i)         state_d = POP;
        else                          state_d = FINISH;
      end
      PUSH: if (xfer) begin
        sp_d   = sp_q - 16'd2;
        push_d = push_rem;
        if (push_rem == '0) state_d = (|pop_q) ? POP : FINISH;
      end
      POP: if (xfer) begin
        // A popped SP overrides the increment; later pops address from it.
        sp_d       = (pop_idx == BIT_SP) ? bus_rdata_i : sp_q + 16'd2;
        pop_d      = pop_rem;
        wb_sel_d   = pop_idx;
        wb_data_d  = bus_rdata_i;
        wb_valid_d = (pop_idx != BIT_SP) && (pop_idx != BIT_SKIP);
        if (pop_rem == '0) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      push_q     <= '0;
      pop_q      <= '0;
      sp_q       <= '0;
      sp_start_q <= '0;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      sp_q       <= sp_d;
      sp_start_q <= sp_start_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_nec_stack_sequencer.sv
// Scoreboard bench: a mask-walking reference model queues expected transfers,
// writebacks and final SP; an independent monitor checks what the DUT does.
module tb_nec_stack_sequencer;

  logic        clk = 1'b0, reset_n = 1'b1, start = 1'b0;
  logic [15:0] push_mask = '0, pop_mask = '0, sp_in = '0, reg_wdata, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        busy, bus_req, bus_we, wb_valid, sp_we, done;
  logic [3:0]  reg_sel, wb_sel;
  logic [15:0] bus_addr, bus_wdata, wb_data, sp_out;

  nec_stack_sequencer dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .push_mask_i(push_mask), .pop_mask_i(pop_mask), .sp_in_i(sp_in),
    .busy_o(busy), .reg_sel_o(reg_sel), .reg_wdata_i(reg_wdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .wb_valid_o(wb_valid), .wb_sel_o(wb_sel), .wb_data_o(wb_data),
    .sp_out_o(sp_out), .sp_we_o(sp_we), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rf_val(input logic [3:0] s);
    return 16'hA500 + 16'h0111 * {12'h0, s};
  endfunction
  assign reg_wdata = rf_val(reg_sel);

  typedef struct {logic we; logic [15:0] addr; logic [15:0] data; logic [3:0] sel;} xfer_t;
  typedef struct {logic [3:0] sel; logic [15:0] data;} wb_t;
  xfer_t       exp_bus[$];
  wb_t         exp_wb[$];
  logic [15:0] exp_sp[$];

  int nvec = 0, nerr = 0, wb_cnt = 0;
  int wait_cfg = 0, wcnt = 0;
  logic [15:0] salt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pushes lowest-first below SP, pops highest-first upward.
  task automatic model(input logic [15:0] pm, input logic [15:0] pp, input logic [15:0] sp0,
                       input logic [15:0] s, output int n, output int nwb);
    logic [15:0] sp, d;
    sp = sp0; n = 0; nwb = 0;
    for (int i = 0; i < 16; i++) if (pm[i] && i != 5) begin
      sp = sp - 16'd2;
      exp_bus.push_back('{we: 1'b1, addr: sp, data: (i == 4) ? sp0 : rf_val(4'(i)), sel: 4'(i)});
      n++;
    end
    for (int i = 15; i >= 0; i--) if (pp[i]) begin
      d = sp ^ s;
      exp_bus.push_back('{we: 1'b0, addr: sp, data: 16'h0, sel: 4'(i)});
      n++;
      sp = sp + 16'd2;
      if (i == 4) sp = d;
      else if (i != 5) begin
        exp_wb.push_back('{sel: 4'(i), data: d});
        nwb++;
      end
    end
    exp_sp.push_back(sp);
  endtask

  // Bus responder: fixed wait states per transfer, read data = address ^ salt.
  initial forever begin
    @(posedge clk); #1;
    if (reset_n && bus_req) begin
      if (wcnt == 0) begin
        bus_ack = 1'b1; bus_rdata = bus_addr ^ salt; wcnt = wait_cfg;
      end else begin
        bus_ack = 1'b0; bus_rdata = 16'($urandom); wcnt--;
      end
    end else bus_ack = 1'b0;
  end

  // Monitor
  logic  pend = 1'b0;
  xfer_t held, me;
  wb_t   mw;
  always @(negedge clk) begin
    if (!reset_n) pend = 1'b0;
    else begin
      if (pend) begin
        chk("hold_req", {31'd0, bus_req}, 32'd1);
        chk("hold_addr", {16'd0, bus_addr}, {16'd0, held.addr});
        chk("hold_we", {31'd0, bus_we}, {31'd0, held.we});
        chk("hold_sel", {28'd0, reg_sel}, {28'd0, held.sel});
        if (held.we) chk("hold_wdata", {16'd0, bus_wdata}, {16'd0, held.data});
      end
      pend = bus_req && !bus_ack;
      if (pend) held = '{we: bus_we, addr: bus_addr, data: bus_wdata, sel: reg_sel};
      if (bus_req && bus_ack) begin
        if (exp_bus.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL stray_req: got addr %h with none expected at %0t", bus_addr, $time);
        end else begin
          me = exp_bus.pop_front();
          chk("bus_we", {31'd0, bus_we}, {31'd0, me.we});
          chk("bus_addr", {16'd0, bus_addr}, {16'd0, me.addr});
          chk("reg_sel", {28'd0, reg_sel}, {28'd0, me.sel});
          if (me.we) chk("bus_wdata", {16'd0, bus_wdata}, {16'd0, me.data});
        end
      end
      if (wb_valid) begin
        wb_cnt++;
        if (exp_wb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL stray_wb: got sel %0d with none expected at %0t", wb_sel, $time);
        end else begin
          mw = exp_wb.pop_front();
          chk("wb_sel", {28'd0, wb_sel}, {28'd0, mw.sel});
          chk("wb_data", {16'd0, wb_data}, {16'd0, mw.data});
        end
      end
      if (done) begin
        chk("done_sp_we", {31'd0, sp_we}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd1);
        if (exp_sp.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL stray_done: got sp %h with none expected at %0t", sp_out, $time);
        end else chk("sp_out", {16'd0, sp_out}, {16'd0, exp_sp.pop_front()});
      end
    end
  end

  task automatic flush();
    exp_bus.delete(); exp_wb.delete(); exp_sp.delete();
  endtask

  task automatic run_seq(input logic [15:0] pm, input logic [15:0] pp, input logic [15:0] sp,
                         input logic [15:0] s, input int w, input bit poke);
    int n, nwb, cyc;
    model(pm, pp, sp, s, n, nwb);
    wb_cnt = 0; salt = s; wait_cfg = w; wcnt = w;
    push_mask = pm; pop_mask = pp; sp_in = sp; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_mask = 16'($urandom); pop_mask = 16'($urandom); sp_in = 16'($urandom);
    cyc = 1;
    while (!done && cyc < 200) begin
      start = (poke && cyc == 2);
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, n * (w + 1) + 1);
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("wb_pulses", wb_cnt, nwb);
    chk("queues_drained", exp_bus.size() + exp_wb.size() + exp_sp.size(), 0);
    flush();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, bus_we}, 32'd0);
    chk({tag, "_addr"}, {16'd0, bus_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, bus_wdata}, 32'd0);
    chk({tag, "_sel"}, {28'd0, reg_sel}, 32'd0);
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wbsel"}, {28'd0, wb_sel}, 32'd0);
    chk({tag, "_wbdata"}, {16'd0, wb_data}, 32'd0);
    chk({tag, "_spout"}, {16'd0, sp_out}, 32'd0);
    chk({tag, "_spwe"}, {31'd0, sp_we}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n, nwb, w;
    logic [15:0] pm, pp;
    #1 reset_n = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    run_seq(16'h01DF, 16'h0000, 16'h1000, 16'h0000, 0, 1'b0);   // PUSH R
    run_seq(16'h0000, 16'h01EF, 16'h0FF0, 16'h0000, 0, 1'b0);   // POP R
    run_seq(16'h4C00, 16'h0000, 16'h0002, 16'h0000, 0, 1'b0);   // interrupt push, wraps
    run_seq(16'h01DF, 16'h0000, 16'h1000, 16'h0000, 3, 1'b0);   // 3 wait states
    run_seq(16'h8000, 16'h4000, 16'h2000, 16'h5A5A, 0, 1'b0);   // combined
    run_seq(16'h0000, 16'h0000, 16'h1234, 16'h0000, 0, 1'b0);   // empty
    run_seq(16'h0020, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);   // skip-only push
    run_seq(16'h0000, 16'h0031, 16'hFFFE, 16'h1357, 1, 1'b0);   // pop SP mid-sequence

    // Reset during the third transfer of PUSH R
    model(16'h01DF, 16'h0000, 16'h1000, 16'h0000, n, nwb);
    salt = '0; wait_cfg = 0; wcnt = 0;
    push_mask = 16'h01DF; pop_mask = '0; sp_in = 16'h1000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_addr", {16'd0, bus_addr}, 32'h0FFA);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    flush();
    @(posedge clk); #1 reset_n = 1'b1;
    run_seq(16'h01DF, 16'h0000, 16'h1000, 16'h0000, 0, 1'b0);

    run_seq(16'h00FF, 16'h00FF, 16'h8000, 16'h0F0F, 1, 1'b1);   // start poked while busy

    for (int k = 0; k < 40; k++) begin
      pm = 16'($urandom); pp = 16'($urandom);
      if (k % 5 == 1) pm = '0;
      if (k % 7 == 2) pp = '0;
      w = int'($urandom_range(0, 2));
      run_seq(pm, pp, 16'($urandom), 16'($urandom), w, (k % 3 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
